// File: rtl/sec60_timer.sv
// sec60_timer: 00..59 seconds stopwatch with run/pause control.
// A 26-bit prescaler divides Clk down to one count per second while running.
// Build option: define SEC60_AUTOSTOP_EN to stop at 59 in DONE. Otherwise
// the count wraps to 00 with a rollover pulse, and done is tied low.
module sec60_timer #(
  parameter int unsigned CLK_DIV = 32'd50000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       sec_tick,
  output logic       rollover,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [25:0] PRESC_TC = 26'(CLK_DIV - 32'd1);

  // Next BCD seconds value, returned as {wrap, tens, ones}.
  // The >= comparisons keep the digits in range even if a digit is corrupted.
  function automatic logic [8:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [8:0] res;
    if (ones >= 4'd9) begin
      if (tens >= 4'd5) begin
        res = {1'b1, 4'd0, 4'd0};
      end else begin
        res = {1'b0, tens + 4'd1, 4'd0};
      end
    end else begin
      res = {1'b0, tens, ones + 4'd1};
    end
    return res;
  endfunction

  state_t      state_r, state_nx_s;
  logic [25:0] presc_r, presc_nx_s;
  logic [3:0]  tens_r, tens_nx_s;
  logic [3:0]  ones_r, ones_nx_s;
  logic        running_r, tick_r, roll_r;
  logic        tick_nx_s, roll_nx_s;
  logic [8:0]  inc_s;

  assign inc_s = bcd_inc(tens_r, ones_r);

  // Next-state, prescaler and count decode; clear overrides everything else.
  always_comb begin
    state_nx_s = state_r;
    presc_nx_s = presc_r;
    tens_nx_s  = tens_r;
    ones_nx_s  = ones_r;
    tick_nx_s  = 1'b0;
    roll_nx_s  = 1'b0;
    if (clear) begin
      state_nx_s = ST_IDLE;
      presc_nx_s = 26'd0;
      tens_nx_s  = 4'd0;
      ones_nx_s  = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          presc_nx_s = 26'd0;
          tens_nx_s  = 4'd0;
          ones_nx_s  = 4'd0;
          state_nx_s = start_stop ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (presc_r == PRESC_TC) begin
            // Terminal count: the increment always lands, even with a pause request.
            presc_nx_s = 26'd0;
            tick_nx_s  = 1'b1;
`ifdef SEC60_AUTOSTOP_EN
            if (inc_s[8]) begin
              state_nx_s = ST_DONE;
            end else begin
              tens_nx_s  = inc_s[7:4];
              ones_nx_s  = inc_s[3:0];
              state_nx_s = start_stop ? ST_PAUSE : ST_RUN;
            end
`else
            tens_nx_s  = inc_s[7:4];
            ones_nx_s  = inc_s[3:0];
            roll_nx_s  = inc_s[8];
            state_nx_s = start_stop ? ST_PAUSE : ST_RUN;
`endif
          end else begin
            presc_nx_s = presc_r + 26'd1;
            state_nx_s = start_stop ? ST_PAUSE : ST_RUN;
          end
        end
        ST_PAUSE: begin
          // Prescaler is held so the partial second survives the pause.
          state_nx_s = start_stop ? ST_RUN : ST_PAUSE;
        end
        ST_DONE: begin
          state_nx_s = ST_DONE;
        end
        default: begin
          state_nx_s = ST_IDLE;
          presc_nx_s = 26'd0;
          tens_nx_s  = 4'd0;
          ones_nx_s  = 4'd0;
        end
      endcase
    end
  end

  // State, prescaler, count and output flag registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r   <= ST_IDLE;
      presc_r   <= 26'd0;
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
      running_r <= 1'b0;
      tick_r    <= 1'b0;
      roll_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      presc_r   <= presc_nx_s;
      tens_r    <= tens_nx_s;
      ones_r    <= ones_nx_s;
      running_r <= (state_nx_s == ST_RUN);
      tick_r    <= tick_nx_s;
      roll_r    <= roll_nx_s;
    end
  end

`ifdef SEC60_AUTOSTOP_EN
  logic done_r;

  // Registered DONE indicator.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_nx_s == ST_DONE);
    end
  end

  assign done = done_r;
`else
  assign done = 1'b0;
`endif

  assign secs_tens = tens_r;
  assign secs_ones = ones_r;
  assign running   = running_r;
  assign sec_tick  = tick_r;
  assign rollover  = roll_r;

endmodule

// File: doc/sec60_timer.md
SEC60_TIMER -- requirements
Module: sec60_timer

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50000000, Clk cycles per second (legal 2..67108864).
REQ-002 SHALL provide ports:
  Clk  input  1  system clock, all logic on rising edge
  Rst  input  1  synchronous reset, active-high
  start_stop  input  1  one-cycle pulse from the pushbutton debouncer; toggles run/pause
  clear  input  1  one-cycle pulse; returns the timer to 00
  secs_tens  output  4  BCD tens digit, 0..5
  secs_ones  output  4  BCD ones digit, 0..9
  running  output  1  high while in RUN
  sec_tick  output  1  one-cycle pulse on every seconds increment
  rollover  output  1  one-cycle pulse on the 59->00 wrap
  done  output  1  high in DONE state (only with SEC60_AUTOSTOP_EN)
REQ-003 SHALL have one clock; reset synchronous, active-high.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-005 IDLE: start_stop -> RUN; count is 00, prescaler 0.
REQ-006 RUN: start_stop -> PAUSE; PAUSE: start_stop -> RUN; DONE: start_stop ignored.
REQ-007 clear in any state -> IDLE, secs 00, prescaler 0, sec_tick/rollover 0 next cycle.
REQ-008 clear and start_stop in the same cycle: clear wins, start_stop discarded.
REQ-009 Prescaler (26 bits) SHALL increment only in RUN, wrap from CLK_DIV-1 to 0; held in PAUSE.
REQ-010 Prescaler at CLK_DIV-1 in RUN SHALL advance count at that edge and assert sec_tick for the following cycle.
REQ-011 First increment SHALL be visible exactly CLK_DIV cycles after running first goes high from IDLE.
REQ-012 running SHALL assert the cycle after the start_stop pulse cycle, deassert the cycle after the pause pulse.
REQ-013 Pause then resume SHALL preserve the partial prescaler count (no lost or extra time).
REQ-014 Increment: ones 9->0 with tens+1; at 59 behaviour per REQ-020/021; digits never leave BCD range.
REQ-015 start_stop coincident with a prescaler terminal count in RUN: increment applied, then PAUSE.
REQ-016 sec_tick and rollover SHALL be exactly one cycle wide; never asserted outside RUN transitions.

Reset
REQ-017 Rst SHALL take priority over clear and start_stop.
REQ-018 On Rst: state IDLE, prescaler 0, secs_tens 0, secs_ones 0, running 0, sec_tick 0, rollover 0, done 0.
REQ-019 Rst asserted mid-RUN SHALL abort the count with no sec_tick/rollover on the following cycle.

Configuration
REQ-020 Macro SEC60_AUTOSTOP_EN undefined: at 59 the increment wraps to 00, rollover pulses with sec_tick, FSM stays RUN; done tied 0; DONE state unreachable.
REQ-021 Macro SEC60_AUTOSTOP_EN defined: at 59 the terminal tick sets count 00? no -- holds 59, enters DONE, running 0, done 1, sec_tick pulses, rollover stays 0; only clear or Rst leaves DONE (to IDLE).

Verification (CLK_DIV=4)
REQ-022 Rst, then start_stop pulse at cycle 10 -> running=1 at 11; secs 00->01 visible at cycle 15 with sec_tick=1 at 15.
REQ-023 Run 2 cycles into a second, pause 20 cycles, resume -> next increment 2 cycles after running re-asserts.
REQ-024 Run from 00 for 240 cycles (autostop off) -> at 59->00 rollover=1 and sec_tick=1 same cycle, running stays 1.
REQ-025 Same with SEC60_AUTOSTOP_EN -> secs hold 59, done=1, running=0; start_stop ignored; clear -> 00, done=0, IDLE.
REQ-026 clear and start_stop same cycle while RUN at 37 -> IDLE, 00, running=0; start_stop on terminal prescaler cycle -> count advances, then PAUSE.
REQ-027 Rst asserted with clear and start_stop mid-RUN -> all outputs at reset values next cycle, no pulses.
